// File: rtl/imul_int_mul_var_lat_pkg.sv
// Shared types and constants for the variable-latency multiplier.
package imul_var_lat_pkg;

    localparam int SHAMT_WIN = 8;
    localparam int SHAMT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imul_int_mul_var_lat_if.sv
// Request/response val/rdy bundle for the multiplier; master is the requester, slave the multiplier.
interface imul_int_mul_var_lat_if #(
    parameter int p_nbits = 32
);
    logic                   req_val;
    logic                   req_rdy;
    logic [2*p_nbits-1:0]   req_msg;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [p_nbits-1:0]     resp_msg;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/imul_int_mul_var_lat_calc_shamt.sv
// Shift-amount calculator: distance to skip in b, from its low 8-bit window.
// Combinational; no handshake.
module imul_IntMulVarLatCalcShamtVRTL
    import imul_var_lat_pkg::*;
(
    input  logic [SHAMT_WIN-1:0] in_,
    output logic [SHAMT_W-1:0]   out
);
    // An empty window skips all of it; bit0 set advances by one after the add.
    always_comb begin
        out = SHAMT_W'(SHAMT_WIN);
        for (int i = SHAMT_WIN - 1; i >= 1; i--) begin
            if (in_[i]) out = SHAMT_W'(i);
        end
        if (in_[0]) out = SHAMT_W'(1);
    end
endmodule

// File: rtl/imul_int_mul_var_lat.sv
// Iterative multiplier, low p_nbits of a*b, skipping zero runs of b. Optional macro IMUL_VARLAT_FAST_ACCEPT_EN.
// Latency: 1+N cycles from request transfer to resp_val (N=1 for b=0, N=p_nbits for b all ones).
// Backpressure: DONE holds the result while resp_rdy=0; requests taken in IDLE (or DONE with resp_rdy under the macro).
module imul_int_mul_var_lat
    import imul_var_lat_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic clk,
    input  logic reset,
    imul_int_mul_var_lat_if.slave bus
);
    state_t               state;
    logic [p_nbits-1:0]   a_reg;
    logic [p_nbits-1:0]   b_reg;
    logic [p_nbits-1:0]   result_reg;
    logic [p_nbits-1:0]   b_next;
    logic [p_nbits-1:0]   a_in;
    logic [p_nbits-1:0]   b_in;
    logic [SHAMT_W-1:0]   shamt;
    logic                 req_rdy;
    logic                 resp_val;
    logic                 req_xfer;
    logic                 resp_xfer;

    imul_IntMulVarLatCalcShamtVRTL u_calc_shamt (
        .in_ (b_reg[SHAMT_WIN-1:0]),
        .out (shamt)
    );

    assign a_in   = bus.req_msg[2*p_nbits-1:p_nbits];
    assign b_in   = bus.req_msg[p_nbits-1:0];
    assign b_next = b_reg >> shamt;

`ifdef IMUL_VARLAT_FAST_ACCEPT_EN
    assign req_rdy = !reset && ((state == IDLE) || ((state == DONE) && bus.resp_rdy));
`else
    assign req_rdy = !reset && (state == IDLE);
`endif
    assign resp_val  = !reset && (state == DONE);
    assign req_xfer  = bus.req_val && req_rdy;
    assign resp_xfer = resp_val && bus.resp_rdy;

    assign bus.req_rdy  = req_rdy;
    assign bus.resp_val = resp_val;
    assign bus.resp_msg = result_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_xfer) begin
                        a_reg      <= a_in;
                        b_reg      <= b_in;
                        result_reg <= '0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (b_reg[0]) result_reg <= result_reg + a_reg;
                    a_reg <= a_reg << shamt;
                    b_reg <= b_next;
                    if (b_next == '0) state <= DONE;
                end
                DONE: begin
                    // req_xfer here implies resp_xfer: reload without an IDLE bubble.
                    if (req_xfer) begin
                        a_reg      <= a_in;
                        b_reg      <= b_in;
                        result_reg <= '0;
                        state      <= CALC;
                    end else if (resp_xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
